// File: rtl/if_queue_pkg.sv
// if_queue shared definitions: reset/stall encodings, zero/nop words, default depth.
// The queue entry is a packed {pc, inst} pair, 64 bits wide.
// Used by if_queue and if_queue_mem.
package if_queue_pkg;

   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [31:0] NopInst    = 32'h0000_0000;
   localparam logic        RstEnable  = 1'b0;
   localparam logic        RstDisable = 1'b1;
   localparam logic        Stop       = 1'b1;
   localparam logic        NoStop     = 1'b0;
   localparam int          IF_QUEUE_DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   localparam entry_t BubbleEntry = '{pc: ZeroWord, inst: NopInst};

endpackage

// File: rtl/if_queue_mem.sv
// Purpose: DEPTH x 64 storage for the prefetch queue, one write port, one async read port.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none here; the owner decides when writes are legal. Data is never reset.
module if_queue_mem
   import if_queue_pkg::*;
#(
   parameter int DEPTH = IF_QUEUE_DEPTH
)(
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  entry_t                   wr_dat,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output entry_t                   rd_dat
);

   entry_t mem [DEPTH];

   // Store the pushed pair at the write pointer.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/if_queue.sv
// Purpose: instruction prefetch queue feeding decode; replaces the IF/ID register (optional IF_QUEUE_STARVE_CNT_EN starve counter).
// Latency: 1 cycle fetch-to-decode when empty (write-through), count+1 cycles behind queued words.
// Backpressure: full_o stalls fetch; a push while full with no pop is dropped and sets sticky ovf_o.
module if_queue
   import if_queue_pkg::*;
#(
   parameter int DEPTH = IF_QUEUE_DEPTH
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  logic [31:0] push_pc_i,
   input  logic [31:0] push_inst_i,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   input  logic        branch_flush_i,
   output logic        full_o,
   output logic        almost_full_o,
   output logic        ovf_o,
`ifdef IF_QUEUE_STARVE_CNT_EN
   output logic [31:0] starve_cnt_o,
`endif
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic   load;
   logic   empty;
   logic   full;
   logic   pop;
   logic   wt;
   logic   wr_en;
   logic   drop;
   logic   out_ld;
   entry_t out_nxt;
   entry_t push_dat;
   entry_t head_dat;
   logic   unused_stall;

   assign unused_stall = ^{stall_i[5:3], stall_i[0]};

   assign push_dat = '{pc: push_pc_i, inst: push_inst_i};
   assign load     = (stall_i[1] == NoStop);
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign pop      = load && !empty;
   assign wt       = load && empty && push_i;

   assign full_o        = full;
   assign almost_full_o = (count >= CW'(DEPTH - 1));

   if_queue_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_dat  (push_dat),
      .rd_addr (rd_ptr),
      .rd_dat  (head_dat)
   );

   // Storage write decision: branch flush keeps a push only into an empty, unloaded queue.
   always_comb begin
      wr_en = 1'b0;
      drop  = 1'b0;
      if (rst == RstDisable && !flush_i) begin
         if (branch_flush_i) begin
            wr_en = !load && empty && push_i;
         end else begin
            wr_en = push_i && !wt && (!full || pop);
            drop  = push_i && full && !pop;
         end
      end
   end

   // Next decode word: head, write-through push, bubble, or hold under a full stall.
   always_comb begin
      out_ld  = 1'b1;
      out_nxt = BubbleEntry;
      if (load) begin
         if (pop) begin
            out_nxt = head_dat;
         end else if (wt) begin
            out_nxt = push_dat;
         end
      end else if (stall_i[2] == Stop) begin
         out_ld = 1'b0;
      end
   end

   // Pointers, count, sticky overflow and the decode-facing output registers.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ovf_o     <= 1'b0;
         id_pc_o   <= ZeroWord;
         id_inst_o <= NopInst;
      end else if (flush_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         id_pc_o   <= ZeroWord;
         id_inst_o <= NopInst;
      end else begin
         if (out_ld) begin
            id_pc_o   <= out_nxt.pc;
            id_inst_o <= out_nxt.inst;
         end
         if (branch_flush_i) begin
            // The delay slot is the only word worth keeping behind a taken branch.
            if (load) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               count  <= '0;
            end else if (!empty) begin
               wr_ptr <= rd_ptr + PW'(1);
               count  <= CW'(1);
            end else if (push_i) begin
               wr_ptr <= wr_ptr + PW'(1);
               count  <= CW'(1);
            end
         end else begin
            if (wr_en) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            if (drop) begin
               ovf_o <= 1'b1;
            end
         end
      end
   end

`ifdef IF_QUEUE_STARVE_CNT_EN
   // Count load events that had nothing to give decode; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         starve_cnt_o <= '0;
      end else if (!flush_i && load && empty && !push_i && starve_cnt_o != 32'hFFFF_FFFF) begin
         starve_cnt_o <= starve_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_queue.sv
// Self-checking bench for if_queue: scoreboard of queued words plus expected decode outputs.
// Directed scenarios (write-through, fill/overflow, bubbles, branch/exception flush) then random traffic.
// Optional starve counter is checked when IF_QUEUE_STARVE_CNT_EN is defined.
module tb_if_queue;
   import if_queue_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_i;
   logic [31:0] push_pc_i;
   logic [31:0] push_inst_i;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        branch_flush_i;
   logic        full_o;
   logic        almost_full_o;
   logic        ovf_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
`ifdef IF_QUEUE_STARVE_CNT_EN
   logic [31:0] starve_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   entry_t      sb_q[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_inst;
   logic        exp_ovf;
   int          exp_starve;
   logic [31:0] next_pc;

   always #5 clk = ~clk;

   if_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .push_i         (push_i),
      .push_pc_i      (push_pc_i),
      .push_inst_i    (push_inst_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .branch_flush_i (branch_flush_i),
      .full_o         (full_o),
      .almost_full_o  (almost_full_o),
      .ovf_o          (ovf_o),
`ifdef IF_QUEUE_STARVE_CNT_EN
      .starve_cnt_o   (starve_cnt_o),
`endif
      .id_pc_o        (id_pc_o),
      .id_inst_o      (id_inst_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc + 32'h0000_1001;
   endfunction

   task automatic check_all(input string tag);
      int n;
      n = sb_q.size();
      chk({tag, ".pc"},    id_pc_o,   exp_pc);
      chk({tag, ".inst"},  id_inst_o, exp_inst);
      chk({tag, ".count"}, 32'(dut.count), 32'(n));
      chk({tag, ".full"},  32'(full_o), 32'(n == DEPTH));
      chk({tag, ".afull"}, 32'(almost_full_o), 32'(n >= DEPTH - 1));
      chk({tag, ".ovf"},   32'(ovf_o), 32'(exp_ovf));
`ifdef IF_QUEUE_STARVE_CNT_EN
      chk({tag, ".starve"}, starve_cnt_o, 32'(exp_starve));
`endif
   endtask

   task automatic do_reset();
      rst = 1'b0; push_i = 1'b0; push_pc_i = '0; push_inst_i = '0;
      stall_i = '0; flush_i = 1'b0; branch_flush_i = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      sb_q.delete();
      exp_pc = '0; exp_inst = '0; exp_ovf = 1'b0; exp_starve = 0;
      check_all("reset");
      rst = 1'b1;
   endtask

   // One clock: drive inputs, advance the scoreboard model, compare after the edge.
   task automatic step(input string tag, input logic p, input logic [5:0] st,
                       input logic fl, input logic bf);
      entry_t w;
      entry_t h;
      int     n;
      logic   ld;
      w = '{pc: next_pc, inst: inst_of(next_pc)};
      push_i = p; push_pc_i = w.pc; push_inst_i = w.inst;
      stall_i = st; flush_i = fl; branch_flush_i = bf;
      if (p) next_pc = next_pc + 32'd4;
      n  = sb_q.size();
      ld = !st[1];
      if (fl) begin
         sb_q.delete();
         exp_pc = '0; exp_inst = '0;
      end else begin
         if (ld) begin
            if (n > 0) begin
               h = sb_q.pop_front();
               exp_pc = h.pc; exp_inst = h.inst;
            end else if (p) begin
               exp_pc = w.pc; exp_inst = w.inst;
            end else begin
               exp_pc = '0; exp_inst = '0;
               exp_starve++;
            end
         end else if (!st[2]) begin
            exp_pc = '0; exp_inst = '0;
         end
         if (bf) begin
            if (ld) sb_q.delete();
            else if (n > 0) while (sb_q.size() > 1) void'(sb_q.pop_back());
            else if (p) sb_q.push_back(w);
         end else if (p && !(ld && n == 0)) begin
            if (n < DEPTH || ld) sb_q.push_back(w);
            else exp_ovf = 1'b1;
         end
      end
      @(posedge clk); #1;
      check_all(tag);
   endtask

   initial begin
      next_pc = 32'h3000_0000;
      do_reset();

      // Write-through with no stall.
      for (int i = 0; i < 3; i++) step("wthru", 1'b1, 6'b000000, 1'b0, 1'b0);
      step("idle", 1'b0, 6'b000000, 1'b0, 1'b0);

      // Fill under a full stall, overflow, then drain.
      for (int i = 0; i < 6; i++) step("fill", 1'b1, 6'b000011, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("drain", 1'b0, 6'b000000, 1'b0, 1'b0);

      // ID-only stall inserts a bubble but keeps queued words.
      step("q2a", 1'b1, 6'b000110, 1'b0, 1'b0);
      step("q2b", 1'b1, 6'b000110, 1'b0, 1'b0);
      step("bubble", 1'b0, 6'b000010, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("post_bub", 1'b0, 6'b000000, 1'b0, 1'b0);

      // Branch flush with load: delay slot out, rest gone, concurrent push dropped.
      for (int i = 0; i < 3; i++) step("abc", 1'b1, 6'b000011, 1'b0, 1'b0);
      step("bf_ld", 1'b1, 6'b000000, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) step("bf_after", 1'b0, 6'b000000, 1'b0, 1'b0);

      // Branch flush without load: keep head only; empty queue keeps the push.
      for (int i = 0; i < 3; i++) step("abc2", 1'b1, 6'b000011, 1'b0, 1'b0);
      step("bf_hold", 1'b1, 6'b000011, 1'b0, 1'b1);
      step("bf_hold_out", 1'b0, 6'b000000, 1'b0, 1'b0);
      step("bf_empty", 1'b1, 6'b000110, 1'b0, 1'b1);
      step("bf_empty_out", 1'b0, 6'b000000, 1'b0, 1'b0);
      step("bf_empty_idle", 1'b0, 6'b000000, 1'b0, 1'b0);

      // Exception flush on a full queue mid-stall with a push.
      for (int i = 0; i < 4; i++) step("fill2", 1'b1, 6'b000011, 1'b0, 1'b0);
      step("flush", 1'b1, 6'b000011, 1'b1, 1'b0);
      step("flush_idle", 1'b0, 6'b000000, 1'b0, 1'b0);

      // Full queue with push and pop every cycle.
      for (int i = 0; i < 4; i++) step("fill3", 1'b1, 6'b000011, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step("stream", 1'b1, 6'b000000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("drain3", 1'b0, 6'b000000, 1'b0, 1'b0);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         logic [5:0] st;
         int r;
         r = $urandom_range(0, 3);
         st = (r == 0) ? 6'b000000 : (r == 1) ? 6'b000010 : (r == 2) ? 6'b000110 : 6'b000000;
         step("rand", 1'($urandom_range(0, 3) != 0), st,
              1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 14) == 0));
      end

      // Starvation count from a clean reset.
      do_reset();
      for (int i = 0; i < 5; i++) step("starve", 1'b0, 6'b000000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
